// File: rtl/shift_unit_seq.sv
// Multi-cycle shifter (SLL/SRL/SRA/ROR) that applies up to STEP positions per cycle,
// with valid/ready on both sides. Optional zero/cout result flags under SHIFT_FLAGS_EN.
module shift_unit_seq #(
  parameter int WIDTH = 32,
  parameter int STEP  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res
`ifdef SHIFT_FLAGS_EN
  ,
  output logic             zero,
  output logic             cout
`endif
);

  // state | meaning
  // IDLE  | ready for a request; res holds the previous result
  // SHIFT | working register advances by min(remaining, STEP) each cycle
  // DONE  | result presented, waiting for out_ready
  localparam int SW = $clog2(WIDTH);
  localparam logic [SW-1:0] STEP_C = SW'(STEP);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_work;
  logic [SW-1:0]    r_rem;
  logic [1:0]       r_op;
  logic             r_sign;

  logic [SW-1:0]      w_n;
  logic [SW-1:0]      w_k;
  logic               w_fill;
  logic [2*WIDTH-1:0] w_sll_ext;
  logic [3*WIDTH-1:0] w_sr_ext;
  logic [2*WIDTH-1:0] w_ror_ext;
  logic [WIDTH-1:0]   w_step;
  logic               w_cout_step;
  logic               w_unused_bits;

  assign w_n    = B[SW-1:0];
  assign w_k    = (r_rem < STEP_C) ? r_rem : STEP_C;
  assign w_fill = (r_op == 2'b10) & r_sign;

  // Widened shifts keep the last bit shifted out at a fixed index for cout.
  assign w_sll_ext = {{WIDTH{1'b0}}, r_work} << w_k;
  assign w_sr_ext  = {{WIDTH{w_fill}}, r_work, {WIDTH{1'b0}}} >> w_k;
  assign w_ror_ext = {r_work, r_work} >> w_k;

  always_comb begin
    w_step      = '0;
    w_cout_step = 1'b0;
    case (r_op)
      2'b00: begin
        w_step      = w_sll_ext[WIDTH-1:0];
        w_cout_step = w_sll_ext[WIDTH];
      end
      2'b01, 2'b10: begin
        w_step      = w_sr_ext[2*WIDTH-1:WIDTH];
        w_cout_step = w_sr_ext[WIDTH-1];
      end
      default: begin
        w_step      = w_ror_ext[WIDTH-1:0];
        w_cout_step = w_ror_ext[WIDTH-1];
      end
    endcase
  end

  assign w_unused_bits = ^{B[WIDTH-1:SW], w_sll_ext[2*WIDTH-1:WIDTH+1],
                           w_sr_ext[3*WIDTH-1:2*WIDTH], w_sr_ext[WIDTH-2:0],
                           w_ror_ext[2*WIDTH-1:WIDTH], w_cout_step};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_nxt = (w_n == '0) ? DONE : SHIFT;
      end
      SHIFT: begin
        if (r_rem <= STEP_C) w_state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_work <= '0;
      r_rem  <= '0;
      r_op   <= '0;
      r_sign <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (in_valid) begin
          r_work <= A;
          r_rem  <= w_n;
          r_op   <= op;
          r_sign <= A[WIDTH-1];
        end
        SHIFT: begin
          r_work <= w_step;
          r_rem  <= r_rem - w_k;
        end
        default: ;
      endcase
    end
  end

  assign res = r_work;

`ifdef SHIFT_FLAGS_EN
  logic r_cout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          r_cout <= 1'b0;
    else if (r_state == IDLE && in_valid) r_cout <= 1'b0;
    else if (r_state == SHIFT)           r_cout <= w_cout_step;
  end

  assign zero = (r_state == DONE) && (r_work == '0);
  assign cout = r_cout;
`endif

endmodule

// File: tb/tb_shift_unit_seq.sv
// Self-checking bench for shift_unit_seq: directed cases plus randomized requests
// checked against an arithmetic reference model; flag checks under SHIFT_FLAGS_EN.
module tb_shift_unit_seq;
  localparam int W    = 32;
  localparam int STEP = 4;
  localparam int SW   = $clog2(W);

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [1:0]   op = '0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] res;
`ifdef SHIFT_FLAGS_EN
  logic         zero;
  logic         cout;
`endif

  int total = 0;
  int bad   = 0;

  logic [W-1:0] exp_res  = '0;
  logic         exp_cout = 1'b0;

  shift_unit_seq #(.WIDTH(W), .STEP(STEP)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .A(A), .B(B), .out_valid(out_valid), .out_ready(out_ready), .res(res)
`ifdef SHIFT_FLAGS_EN
    , .zero(zero), .cout(cout)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] model_res(input logic [1:0] o, input logic [W-1:0] a, input int n);
    case (o)
      2'b00:   return a << n;
      2'b01:   return a >> n;
      2'b10:   return $signed(a) >>> n;
      default: return (n == 0) ? a : ((a >> n) | (a << (W - n)));
    endcase
  endfunction

  function automatic logic model_cout(input logic [1:0] o, input logic [W-1:0] a, input int n);
    logic [W-1:0] r;
    if (n == 0) return 1'b0;
    r = model_res(o, a, n);
    case (o)
      2'b00:        return a[W-n];
      2'b01, 2'b10: return a[n-1];
      default:      return r[W-1];
    endcase
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, expv, $time);
    end
  endtask

  // Every cycle a result is presented it must match the model and block new requests.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      check("mon_res", res, exp_res);
      check("mon_in_ready", W'(in_ready), '0);
`ifdef SHIFT_FLAGS_EN
      check("mon_zero", W'(zero), W'(exp_res == '0));
      check("mon_cout", W'(cout), W'(exp_cout));
`endif
    end
  end

  task automatic accept(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    int t;
    t = 0;
    @(negedge clk);
    while (!in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) check("in_ready_timeout", '0, W'(1));
    op = o; A = a; B = b; in_valid = 1'b1;
    exp_res  = model_res(o, a, int'(b[SW-1:0]));
    exp_cout = model_cout(o, a, int'(b[SW-1:0]));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    op = 2'($urandom); A = $urandom; B = $urandom;
  endtask

  task automatic run_req(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                         input int hold, input bit pulse, output logic [W-1:0] got);
    int lat;
    int n;
    n = int'(b[SW-1:0]);
    accept(o, a, b);
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("latency", W'(lat), W'((n + STEP - 1) / STEP));
    got = res;
    for (int i = 0; i < hold; i++) begin
      in_valid = pulse;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      check("bp_out_valid", W'(out_valid), W'(1));
      check("bp_res_stable", res, got);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("release_out_valid", W'(out_valid), '0);
    check("release_in_ready", W'(in_ready), W'(1));
  endtask

  logic [W-1:0] got;

  initial begin
    #2;
    check("rst_in_ready", W'(in_ready), W'(1));
    check("rst_out_valid", W'(out_valid), '0);
    check("rst_res", res, '0);
`ifdef SHIFT_FLAGS_EN
    check("rst_zero", W'(zero), '0);
    check("rst_cout", W'(cout), '0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    run_req(2'b01, 32'h000000A5, 32'd2, 0, 0, got);  check("srl_a5_2", got, 32'h00000029);
    run_req(2'b01, 32'h000000A5, 32'd1, 0, 0, got);  check("srl_a5_1", got, 32'h00000052);
    run_req(2'b10, 32'h80000000, 32'd4, 0, 0, got);  check("sra_neg", got, 32'hF8000000);
    run_req(2'b10, 32'h40000000, 32'd4, 0, 0, got);  check("sra_pos", got, 32'h04000000);
    run_req(2'b11, 32'h000000A5, 32'd8, 0, 0, got);  check("ror_8", got, 32'hA5000000);
    run_req(2'b00, 32'h00000001, 32'd31, 0, 0, got); check("sll_31", got, 32'h80000000);
    run_req(2'b00, 32'h00000001, 32'd33, 0, 0, got); check("sll_mask", got, 32'h00000002);
    run_req(2'b01, 32'h12345678, 32'd0, 0, 0, got);  check("n0_passthru", got, 32'h12345678);
    run_req(2'b11, 32'h0000F00D, 32'd12, 5, 1, got); check("bp_ror", got, 32'h00D0000F);
`ifdef SHIFT_FLAGS_EN
    run_req(2'b01, 32'h00000001, 32'd1, 0, 0, got);
    check("flag_res0", got, '0);
    run_req(2'b00, 32'h80000000, 32'd1, 0, 0, got);
    check("flag_sll_res", got, '0);
`endif

    // Abort a long shift with an asynchronous reset between clock edges.
    accept(2'b00, 32'h00000001, 32'd31);
    @(posedge clk);
    @(posedge clk);
    #1;
    check("mid_in_ready", W'(in_ready), '0);
    check("mid_out_valid", W'(out_valid), '0);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", W'(out_valid), '0);
    check("abort_res", res, '0);
    check("abort_in_ready", W'(in_ready), W'(1));
    @(negedge clk);
    rst_n = 1'b1;
    run_req(2'b01, 32'h000000A5, 32'd2, 0, 0, got); check("post_abort", got, 32'h00000029);

    for (int i = 0; i < 200; i++) begin
      logic [1:0]   ro;
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      ro = 2'($urandom);
      ra = $urandom;
      rb = $urandom;
      if (i % 4 == 0) ra[W-1] = 1'b1;
      run_req(ro, ra, rb, int'($urandom_range(0, 3)), 1'($urandom), got);
      check("rand_res", got, model_res(ro, ra, int'(rb[SW-1:0])));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end
endmodule
